// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands LM/SM into one single-register micro-op per mask bit and stalls fetch meanwhile.
// Define LMSM_WRITEBACK_EN to append an ADI RA,RA,#popcount micro-op after each non-empty LM/SM.
module lmsm_sequencer #(
    parameter int IW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] ir_in,
    input  logic          valid_in,
    input  logic          hold,
    output logic [IW-1:0] ir_out,
    output logic          valid_out,
    output logic [2:0]    addr_off,
    output logic          last,
    output logic          stall_fetch,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        WB   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            valid_q, valid_d;
    logic [2:0]      addr_off_q, addr_off_d;
    logic            last_q, last_d;
    logic [NREG-1:0] rem_q, rem_d;
    logic [2:0]      count_q, count_d;

    logic            is_lmsm;
    logic [NREG-1:0] in_mask;
    logic [NREG-1:0] in_pick;
    logic [NREG-1:0] rem_pick;

    // Two's-complement trick: m & -m isolates the lowest set bit as a one-hot.
    function automatic logic [NREG-1:0] lowest_bit(input logic [NREG-1:0] m);
        return m & (~m + NREG'(1));
    endfunction

    assign is_lmsm  = (ir_in[IW-1:IW-3] == 3'b011);
    assign in_mask  = ir_in[NREG-1:0];
    assign in_pick  = lowest_bit(in_mask);
    assign rem_pick = lowest_bit(rem_q);

`ifdef LMSM_WRITEBACK_EN
    logic [2:0] wb_ra;
    logic [3:0] wb_pop;

    assign wb_ra  = ir_q[IW-5:IW-7];
    // count wraps to 0 only after all eight transfers, which then means eight.
    assign wb_pop = {count_q == 3'd0, count_q};
`endif

    // NOTE: every signal written here gets its default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        valid_d    = valid_q;
        addr_off_d = addr_off_q;
        last_d     = last_q;
        rem_d      = rem_q;
        count_d    = count_q;

        if (!hold) begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    if (valid_in) begin
                        if (!is_lmsm) begin
                            ir_d       = ir_in;
                            valid_d    = 1'b1;
                            addr_off_d = 3'd0;
                            last_d     = 1'b1;
                        end else if (in_mask == '0) begin
                            ir_d       = ir_in;
                            addr_off_d = 3'd0;
                            last_d     = 1'b0;
                        end else begin
                            ir_d       = {ir_in[IW-1:NREG], in_pick};
                            valid_d    = 1'b1;
                            addr_off_d = 3'd0;
                            rem_d      = in_mask & ~in_pick;
                            count_d    = 3'd1;
                            last_d     = 1'b0;
                            if (rem_d != '0) begin
                                state_d = SEQ;
                            end else begin
`ifdef LMSM_WRITEBACK_EN
                                state_d = WB;
`else
                                last_d  = 1'b1;
`endif
                            end
                        end
                    end
                end

                SEQ: begin
                    // The header byte (opcode, RA, IR[8]) is still held in the upper bits of ir_q.
                    ir_d       = {ir_q[IW-1:NREG], rem_pick};
                    valid_d    = 1'b1;
                    addr_off_d = count_q;
                    rem_d      = rem_q & ~rem_pick;
                    count_d    = count_q + 3'd1;
                    last_d     = 1'b0;
                    if (rem_d == '0) begin
`ifdef LMSM_WRITEBACK_EN
                        state_d = WB;
`else
                        state_d = IDLE;
                        last_d  = 1'b1;
`endif
                    end
                end

`ifdef LMSM_WRITEBACK_EN
                WB: begin
                    ir_d       = {4'b0001, wb_ra, wb_ra, 6'(wb_pop)};
                    valid_d    = 1'b1;
                    addr_off_d = 3'd0;
                    last_d     = 1'b1;
                    state_d    = IDLE;
                end
`endif

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            valid_q    <= 1'b0;
            addr_off_q <= 3'd0;
            last_q     <= 1'b0;
            rem_q      <= '0;
            count_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            valid_q    <= valid_d;
            addr_off_q <= addr_off_d;
            last_q     <= last_d;
            rem_q      <= rem_d;
            count_q    <= count_d;
        end
    end

    assign ir_out      = ir_q;
    assign valid_out   = valid_q;
    assign addr_off    = addr_off_q;
    assign last        = last_q;
    assign stall_fetch = (state_q != IDLE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Testbench for lmsm_sequencer: directed vector table followed by random traffic against a queue-based model.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir_in;
    logic        valid_in;
    logic        hold;
    logic [15:0] ir_out;
    logic        valid_out;
    logic [2:0]  addr_off;
    logic        last;
    logic        stall_fetch;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    lmsm_sequencer #(.IW(16), .NREG(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_in      (ir_in),
        .valid_in   (valid_in),
        .hold       (hold),
        .ir_out     (ir_out),
        .valid_out  (valid_out),
        .addr_off   (addr_off),
        .last       (last),
        .stall_fetch(stall_fetch),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // chk bits: 0 = ir_out, 1 = addr_off, 2 = last; valid/stall/busy always compared.
    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic        vin;
        logic        hld;
        logic [15:0] e_ir;
        logic        e_v;
        logic [2:0]  e_a;
        logic        e_l;
        logic        e_st;
        logic [2:0]  chk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [15:0] ir, input logic vin, input logic hld,
                                input logic [15:0] e_ir, input logic e_v, input logic [2:0] e_a,
                                input logic e_l, input logic e_st, input logic [2:0] chk);
        vec_t v;
        v.rst = rst; v.ir = ir; v.vin = vin; v.hld = hld;
        v.e_ir = e_ir; v.e_v = e_v; v.e_a = e_a; v.e_l = e_l; v.e_st = e_st; v.chk = chk;
        vecs.push_back(v);
    endfunction

    // Reference model: pending micro-ops of the current LM/SM kept as a queue.
    typedef struct {
        logic [15:0] ir;
        logic [2:0]  a;
        logic        l;
    } uop_t;

    uop_t        pend[$];
    logic [15:0] m_ir;
    logic        m_v;
    logic [2:0]  m_a;
    logic        m_l;
    logic [2:0]  m_known;

    function automatic void model_step(input logic rst, input logic [15:0] ir, input logic vin, input logic hld);
        uop_t u;
        int   idx;
        if (rst) begin
            pend.delete();
            m_ir = '0; m_v = 1'b0; m_a = '0; m_l = 1'b0; m_known = 3'b111;
        end else if (hld) begin
            // everything frozen
        end else if (pend.size() != 0) begin
            u = pend.pop_front();
            m_ir = u.ir; m_a = u.a; m_l = u.l; m_v = 1'b1; m_known = 3'b111;
        end else if (!vin) begin
            m_v = 1'b0; m_known = 3'b000;
        end else if (ir[15:12] != 4'h6 && ir[15:12] != 4'h7) begin
            m_ir = ir; m_v = 1'b1; m_a = '0; m_l = 1'b1; m_known = 3'b111;
        end else if (ir[7:0] == 8'h00) begin
            m_ir = ir; m_v = 1'b0; m_l = 1'b0; m_known = 3'b101;
        end else begin
            idx = 0;
            for (int i = 0; i < 8; i++) begin
                if (ir[i]) begin
                    u.ir = {ir[15:8], 8'(1 << i)};
                    u.a  = 3'(idx);
                    u.l  = 1'b0;
                    pend.push_back(u);
                    idx++;
                end
            end
`ifdef LMSM_WRITEBACK_EN
            u.ir = {4'b0001, ir[11:9], ir[11:9], 6'($countones(ir[7:0]))};
            u.a  = 3'd0;
            u.l  = 1'b1;
            pend.push_back(u);
`else
            pend[pend.size()-1].l = 1'b1;
`endif
            u = pend.pop_front();
            m_ir = u.ir; m_a = u.a; m_l = u.l; m_v = 1'b1; m_known = 3'b111;
        end
    endfunction

    initial begin
        vec_t v;
        logic exp_st;

        reset = 1'b1; ir_in = '0; valid_in = 1'b0; hold = 1'b0;

`ifdef LMSM_WRITEBACK_EN
        add(1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 3'b111);
        add(0, 16'h6403, 1, 0, 16'h6401, 1, 0, 0, 1, 3'b111);
        add(0, 16'hFFFF, 1, 0, 16'h6402, 1, 1, 0, 1, 3'b111);
        add(0, 16'hFFFF, 1, 0, 16'h1482, 1, 0, 1, 0, 3'b111);
        add(0, 16'h6400, 1, 0, 16'h6400, 0, 0, 0, 0, 3'b101);
        add(0, 16'h0298, 1, 0, 16'h0298, 1, 0, 1, 0, 3'b111);
        add(0, 16'h7F01, 1, 0, 16'h7F01, 1, 0, 0, 1, 3'b111);
        add(0, 16'h0000, 1, 0, 16'h1FC1, 1, 0, 1, 0, 3'b111);
`else
        add(1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 3'b111);
        add(0, 16'h0298, 1, 0, 16'h0298, 1, 0, 1, 0, 3'b111);
        add(0, 16'h6C25, 1, 0, 16'h6C01, 1, 0, 0, 1, 3'b111);
        add(0, 16'h1234, 1, 0, 16'h6C04, 1, 1, 0, 1, 3'b111);
        add(0, 16'h1234, 1, 0, 16'h6C20, 1, 2, 1, 0, 3'b111);
        add(0, 16'h3ABC, 1, 0, 16'h3ABC, 1, 0, 1, 0, 3'b111);
        add(0, 16'h7280, 1, 1, 16'h3ABC, 1, 0, 1, 0, 3'b111);
        add(0, 16'h7280, 1, 1, 16'h3ABC, 1, 0, 1, 0, 3'b111);
        add(0, 16'h7280, 1, 1, 16'h3ABC, 1, 0, 1, 0, 3'b111);
        add(0, 16'h7280, 1, 0, 16'h7280, 1, 0, 1, 0, 3'b111);
        add(0, 16'h7E0A, 1, 0, 16'h7E02, 1, 0, 0, 1, 3'b111);
        add(0, 16'h0298, 1, 1, 16'h7E02, 1, 0, 0, 1, 3'b111);
        add(0, 16'h0298, 1, 1, 16'h7E02, 1, 0, 0, 1, 3'b111);
        add(0, 16'h0298, 1, 0, 16'h7E08, 1, 1, 1, 0, 3'b111);
        add(0, 16'h6000, 1, 0, 16'h6000, 0, 0, 0, 0, 3'b101);
        add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 3'b000);
        add(0, 16'h61FF, 1, 0, 16'h6101, 1, 0, 0, 1, 3'b111);
        add(0, 16'h0000, 1, 0, 16'h6102, 1, 1, 0, 1, 3'b111);
        add(0, 16'h0000, 1, 0, 16'h6104, 1, 2, 0, 1, 3'b111);
        add(1, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0, 3'b111);
        add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 3'b000);
        add(0, 16'h70FF, 1, 0, 16'h7001, 1, 0, 0, 1, 3'b111);
        for (int k = 1; k < 8; k++)
            add(0, 16'h0000, 0, 0, 16'h7000 | 16'(1 << k), 1, 3'(k), (k == 7), (k != 7), 3'b111);
`endif

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset = v.rst; ir_in = v.ir; valid_in = v.vin; hold = v.hld;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(v.e_v));
            check($sformatf("vec%0d_stall", i), 32'(stall_fetch), 32'(v.e_st));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(v.e_st));
            if (v.chk[0]) check($sformatf("vec%0d_ir", i), 32'(ir_out), 32'(v.e_ir));
            if (v.chk[1]) check($sformatf("vec%0d_addr", i), 32'(addr_off), 32'(v.e_a));
            if (v.chk[2]) check($sformatf("vec%0d_last", i), 32'(last), 32'(v.e_l));
        end

        // Random traffic; first cycle forces a reset so DUT and model start aligned.
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] r_ir;
            r_ir = 16'($urandom);
            if ($urandom_range(0, 3) < 2) r_ir[15:12] = ($urandom_range(0, 1) == 0) ? 4'h6 : 4'h7;
            if ($urandom_range(0, 5) == 0) r_ir[7:0] = 8'h00;
            reset    = (c == 0) || ($urandom_range(0, 59) == 0);
            ir_in    = r_ir;
            valid_in = ($urandom_range(0, 7) != 0);
            hold     = ($urandom_range(0, 4) == 0);
            model_step(reset, ir_in, valid_in, hold);
            exp_st = (pend.size() != 0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rnd%0d_valid", c), 32'(valid_out), 32'(m_v));
            check($sformatf("rnd%0d_stall", c), 32'(stall_fetch), 32'(exp_st));
            check($sformatf("rnd%0d_busy", c), 32'(busy), 32'(exp_st));
            if (m_known[0]) check($sformatf("rnd%0d_ir", c), 32'(ir_out), 32'(m_ir));
            if (m_known[1]) check($sformatf("rnd%0d_addr", c), 32'(addr_off), 32'(m_a));
            if (m_known[2]) check($sformatf("rnd%0d_last", c), 32'(last), 32'(m_l));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
